// File: rtl/scr64b66b_pkg.sv
// Shared constants, lane FSM encoding and warm-up sizing for the 64b66b
// self-synchronising descrambler (G(x) = 1 + x^39 + x^58).
package scr64b66b_pkg;

   localparam int SCR_STATE_W = 58;
   localparam int SCR_TAP_A   = 38;
   localparam int SCR_TAP_B   = 57;

   typedef enum logic {
      WARM   = 1'b0,
      LOCKED = 1'b1
   } lane_state_e;

   // Number of words needed before the whole history comes from received data
   function automatic int scr_warm_words(input int width);
      return (SCR_STATE_W + width - 1) / width;
   endfunction

endpackage

// File: rtl/descrambler_lane.sv
// One descrambler lane: 58-bit history, warm-up/lock FSM and registered
// outputs; history advances on every valid word, bypassed or not.
module descrambler_lane
   import scr64b66b_pkg::*;
#(
   parameter int DATA_WIDTH = 62
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  bypass_i,
   input  logic                  resync_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  locked_o
);

   localparam int WARM_WORDS = scr_warm_words(DATA_WIDTH);
   localparam int CNT_W      = $clog2(WARM_WORDS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARM_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SCR_STATE_W-1:0] hist_q;
   logic [SCR_STATE_W-1:0] hist_d;
   logic [DATA_WIDTH-1:0]  descr_d;
   logic [DATA_WIDTH-1:0]  data_q;
   logic [CNT_W-1:0]       cnt_q;
   lane_state_e            state_q;
   logic                   valid_q;
   logic                   locked_q;

   // Bit-serial descramble unrolled over the word; later bits see earlier ones
   always_comb begin
      hist_d  = hist_q;
      descr_d = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         descr_d[i] = data_i[i] ^ hist_d[SCR_TAP_A] ^ hist_d[SCR_TAP_B];
         hist_d     = {hist_d[SCR_STATE_W-2:0], data_i[i]};
      end
   end

   // Lane history, warm-up FSM and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hist_q   <= '0;
         cnt_q    <= '0;
         state_q  <= WARM;
         data_q   <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
      end else if (resync_i) begin
         hist_q   <= '0;
         cnt_q    <= '0;
         state_q  <= WARM;
         data_q   <= data_q;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
      end else if (valid_i) begin
         hist_q  <= hist_d;
         data_q  <= bypass_i ? data_i : descr_d;
         valid_q <= bypass_i | (state_q == LOCKED);
         if (state_q == WARM) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_q  <= LOCKED;
               locked_q <= 1'b1;
            end else begin
               state_q  <= WARM;
               locked_q <= 1'b0;
            end
         end else begin
            cnt_q    <= cnt_q;
            state_q  <= state_q;
            locked_q <= locked_q;
         end
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign data_o   = data_q;
   assign valid_o  = valid_q;
   assign locked_o = locked_q;

endmodule

// File: rtl/descrambler_multilane.sv
// Multi-lane 64b66b RX descrambler: slices the lane buses and fans out
// bypass to one descrambler_lane per lane.
module descrambler_multilane
   import scr64b66b_pkg::*;
#(
   parameter int DATA_WIDTH = 62,
   parameter int NUM_LANES  = 4
) (
   input  logic                            USER_CLK,
   input  logic                            SYSTEM_RESET,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] SCRAMBLED_DATA_IN,
   input  logic [NUM_LANES-1:0]            DATA_VALID_IN,
   input  logic                            BYPASS_IN,
   input  logic [NUM_LANES-1:0]            LANE_RESYNC_IN,
   output logic [NUM_LANES*DATA_WIDTH-1:0] UNSCRAMBLED_DATA_OUT,
   output logic [NUM_LANES-1:0]            DATA_VALID_OUT,
   output logic [NUM_LANES-1:0]            LANE_LOCKED
);

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      descrambler_lane #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .clk_i    (USER_CLK),
         .rst_i    (SYSTEM_RESET),
         .bypass_i (BYPASS_IN),
         .resync_i (LANE_RESYNC_IN[l]),
         .valid_i  (DATA_VALID_IN[l]),
         .data_i   (SCRAMBLED_DATA_IN[l*DATA_WIDTH +: DATA_WIDTH]),
         .data_o   (UNSCRAMBLED_DATA_OUT[l*DATA_WIDTH +: DATA_WIDTH]),
         .valid_o  (DATA_VALID_OUT[l]),
         .locked_o (LANE_LOCKED[l])
      );
   end

endmodule
